// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : ALU control codes and execute-ALU state encoding, shared with
//             the ALU-control decoder.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   // 3-bit op codes produced by the ALU-control decoder
   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_MUL = 3'b100,
      ALU_SUB = 3'b110
   } aluctrl_e;

   // Execute-ALU sequencing states
   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/ex_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : ex_alu_if
//  Brief    : Operand/result bus of the execute-stage ALU. The slave modport
//             is the ALU side, the master modport the pipeline side.
//  Revision : 1.0  initial release
// ============================================================================
interface ex_alu_if #(
   parameter int WIDTH = 32
) ();
   logic             valid_i;
   logic             ready_o;
   logic [2:0]       aluctrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic             flush_i;
   logic             valid_o;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;

   modport slave (
      input  valid_i, aluctrl_i, data1_i, data2_i, flush_i,
      output ready_o, valid_o, result_o, zero_o
   );

   modport master (
      output valid_i, aluctrl_i, data1_i, data2_i, flush_i,
      input  ready_o, valid_o, result_o, zero_o
   );
endinterface : ex_alu_if
`default_nettype wire

// File: rtl/ex_alu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : ex_alu_mul_iter
//  Brief    : Iterative shift-add multiplier datapath, MUL_BITS multiplier
//             bits per step, low-half product. o_last flags the step whose
//             accumulated value is the final product (o_product).
//             Option EX_ALU_MUL_EARLY_EXIT_EN: o_last also asserts once the
//             remaining multiplier is exhausted.
//  Revision : 1.0  initial release
// ============================================================================
module ex_alu_mul_iter #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_start,
   input  wire logic             i_step,
   input  wire logic             i_abort,
   input  wire logic [WIDTH-1:0] i_mcand,
   input  wire logic [WIDTH-1:0] i_mplier,
   output logic                  o_last,
   output logic [WIDTH-1:0]      o_product
);
   localparam int c_N     = WIDTH / MUL_BITS;
   localparam int c_CNT_W = $clog2(c_N + 1);

   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [WIDTH-1:0]   r_acc;
   logic [c_CNT_W-1:0] r_count;
   logic [WIDTH-1:0]   w_pp;
   logic [WIDTH-1:0]   w_mplier_next;

   // Partial product: a plain gate for one bit per step, a narrow multiply otherwise
   if (MUL_BITS == 1) begin : g_pp_bit
      assign w_pp = r_mplier[0] ? r_mcand : '0;
   end else begin : g_pp_mul
      assign w_pp = r_mcand * {{(WIDTH-MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
   end

   assign w_mplier_next = r_mplier >> MUL_BITS;
   assign o_product     = r_acc + w_pp;

`ifdef EX_ALU_MUL_EARLY_EXIT_EN
   assign o_last = (r_count == c_CNT_W'(c_N - 1)) || (w_mplier_next == '0);
`else
   assign o_last = (r_count == c_CNT_W'(c_N - 1));
`endif

   // Operand load on start, one shift-add per step, counter cleared on finish/abort
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (i_start) begin
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_acc    <= '0;
         r_count  <= '0;
      end else if (i_abort) begin
         r_count  <= '0;
      end else if (i_step) begin
         r_mcand  <= r_mcand << MUL_BITS;
         r_mplier <= w_mplier_next;
         r_acc    <= o_product;
         r_count  <= o_last ? '0 : r_count + c_CNT_W'(1);
      end
   end
endmodule : ex_alu_mul_iter
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// ============================================================================
//  Module   : ex_alu
//  Brief    : Execute-stage ALU. AND/OR/ADD/SUB in one cycle, MUL on an
//             iterative shift-add engine with ready back-pressure. Result and
//             zero flag are registered and held until the next valid_o.
//             Option EX_ALU_MUL_EARLY_EXIT_EN: MUL finishes as soon as the
//             remaining multiplier is zero.
//  Revision : 1.0  initial release
// ============================================================================
module ex_alu
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  wire logic   clk_i,
   input  wire logic   rst_i,
   ex_alu_if.slave     bus
);
   state_e             r_state;
   state_e             w_state_next;
   logic               r_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               w_ready;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_mul_start;
   logic               w_mul_step;
   logic               w_mul_abort;
   logic               w_mul_last;
   logic               w_mul_done;
   logic [WIDTH-1:0]   w_mul_product;
   logic [WIDTH-1:0]   w_alu_res;

   assign w_ready     = (r_state == IDLE);
   assign w_accept    = bus.valid_i && w_ready && !bus.flush_i;
   assign w_is_mul    = (bus.aluctrl_i == ALU_MUL);
   assign w_mul_start = w_accept && w_is_mul;
   assign w_mul_step  = (r_state == MUL_BUSY) && !bus.flush_i;
   assign w_mul_abort = (r_state == MUL_BUSY) && bus.flush_i;
   assign w_mul_done  = w_mul_step && w_mul_last;

   assign bus.ready_o  = w_ready;
   assign bus.valid_o  = r_valid;
   assign bus.result_o = r_result;
   assign bus.zero_o   = r_zero;

   ex_alu_mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_BITS (MUL_BITS)
   ) u_mul (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_start   (w_mul_start),
      .i_step    (w_mul_step),
      .i_abort   (w_mul_abort),
      .i_mcand   (bus.data1_i),
      .i_mplier  (bus.data2_i),
      .o_last    (w_mul_last),
      .o_product (w_mul_product)
   );

   // Single-cycle ops; undefined codes (and MUL, handled elsewhere) give zero
   always_comb begin
      w_alu_res = '0;
      case (bus.aluctrl_i)
         ALU_AND: w_alu_res = bus.data1_i & bus.data2_i;
         ALU_OR:  w_alu_res = bus.data1_i | bus.data2_i;
         ALU_ADD: w_alu_res = bus.data1_i + bus.data2_i;
         ALU_SUB: w_alu_res = bus.data1_i - bus.data2_i;
         default: w_alu_res = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next state: enter MUL_BUSY on an accepted MUL, leave on last step or flush
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (w_mul_start) w_state_next = MUL_BUSY;
         MUL_BUSY: if (w_mul_abort || w_mul_done) w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   // Output registers: one-cycle valid pulse, result/zero held between results
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_valid <= 1'b0;
         if (w_accept && !w_is_mul) begin
            r_valid  <= 1'b1;
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
         end else if (w_mul_done) begin
            r_valid  <= 1'b1;
            r_result <= w_mul_product;
            r_zero   <= (w_mul_product == '0);
         end
      end
   end
endmodule : ex_alu
`default_nettype wire

// File: tb/tb_ex_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_alu
//  Brief    : Self-checking bench for ex_alu. Stimulus pushes the expected
//             result, zero flag and output cycle; a monitor pops on valid_o.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_alu;
   import alu_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        zero;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_pass;
   int   n_total;
   exp_t sb[$];

   ex_alu_if #(.WIDTH(32)) bus ();

   ex_alu #(
      .WIDTH    (32),
      .MUL_BITS (1)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Present an op, hold it until accepted, then queue the expected response
   task automatic issue(input string name, input logic [2:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input bit push,
                        output int acc_cyc);
      bit ok;
      int n;
      exp_t e;
      bus.valid_i   = 1'b1;
      bus.aluctrl_i = ctrl;
      bus.data1_i   = a;
      bus.data2_i   = b;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         ok = bus.ready_o && !bus.flush_i;
         @(posedge clk);
         #1;
         n++;
      end
      bus.valid_i = 1'b0;
      acc_cyc = cyc;
      if (!ok) begin
         n_total++;
         $display("FAIL %s.accept: got no accept expected accept within 200 cycles", name);
      end else if (push) begin
         e.name = name;
         e.res  = res;
         e.zero = (res == 32'h0);
         e.cyc  = cyc + lat - 1;
         sb.push_back(e);
      end
   endtask

   // Monitor: every valid_o must match the oldest expected response
   always @(negedge clk) begin
      exp_t e;
      if (bus.valid_o) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid: got valid_o=1 result=%0h expected no output", bus.result_o);
         end else begin
            e = sb.pop_front();
            check({e.name, ".res"},  bus.result_o, e.res);
            check({e.name, ".zero"}, {31'h0, bus.zero_o}, {31'h0, e.zero});
            check({e.name, ".lat"},  cyc, e.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a3, a4, am, aa, rc;
      int lat0, lat3, lat8;
      n_pass  = 0;
      n_total = 0;
      cyc     = 0;
      rst     = 1'b1;
      bus.valid_i   = 1'b0;
      bus.flush_i   = 1'b0;
      bus.aluctrl_i = 3'b000;
      bus.data1_i   = '0;
      bus.data2_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.ready",  {31'h0, bus.ready_o}, 32'h1);
      check("rst.valid",  {31'h0, bus.valid_o}, 32'h0);
      check("rst.result", bus.result_o, 32'h0);
      check("rst.zero",   {31'h0, bus.zero_o}, 32'h1);
      rst = 1'b0;

      // Back-to-back single-cycle ops
      issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1'b1, a1);
      issue("sub_eq",   ALU_SUB, 32'h5, 32'h5, 32'h0, 1, 1'b1, a2);
      issue("and",      ALU_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1, 1'b1, a3);
      issue("or",       ALU_OR,  32'h1, 32'h2, 32'h3, 1, 1'b1, a4);
      check("b2b.accept_span", a4 - a1, 32'd3);
      check("b2b.ready", {31'h0, bus.ready_o}, 32'h1);

      // Full-length MUL and its ready window
      issue("mul_7x6", ALU_MUL, 32'd7, 32'd6, 32'd42, 33, 1'b1, am);
      rc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.ready_o) break;
         rc++;
      end
      check("mul.ready_low_cycles", rc, 32'd32);
      @(posedge clk); #1;
      issue("mul_wrap", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 1'b1, am);

      // Flush mid-multiply: no output, result held, then a normal ADD
      issue("mul_flushed", ALU_MUL, 32'd5, 32'd5, 32'd0, 33, 1'b0, am);
      repeat (9) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      check("flush.ready",  {31'h0, bus.ready_o}, 32'h1);
      check("flush.valid",  {31'h0, bus.valid_o}, 32'h0);
      check("flush.result", bus.result_o, 32'hFFFF_FFFE);
      issue("add_2_3", ALU_ADD, 32'd2, 32'd3, 32'd5, 1, 1'b1, aa);

      // Reset in the middle of a multiply
      issue("mul_reset", ALU_MUL, 32'd3, 32'd3, 32'd0, 33, 1'b0, am);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst.ready",  {31'h0, bus.ready_o}, 32'h1);
      check("midrst.valid",  {31'h0, bus.valid_o}, 32'h0);
      check("midrst.result", bus.result_o, 32'h0);
      check("midrst.zero",   {31'h0, bus.zero_o}, 32'h1);
      rst = 1'b0;

      // valid_i coincident with flush_i is not accepted
      bus.valid_i   = 1'b1;
      bus.aluctrl_i = ALU_ADD;
      bus.data1_i   = 32'd1;
      bus.data2_i   = 32'd1;
      bus.flush_i   = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      check("flush_in.valid", {31'h0, bus.valid_o}, 32'h0);
      repeat (3) @(posedge clk);
      #1;

      // ADD held during MUL_BUSY is taken in the MUL's valid_o cycle
      issue("mul_4x5", ALU_MUL, 32'd4, 32'd5, 32'd20, 33, 1'b1, am);
      issue("add_held", ALU_ADD, 32'd10, 32'd20, 32'd30, 1, 1'b1, aa);
      check("held.accept_cycle", aa - am, 32'd33);
      issue("undef_111", 3'b111, 32'h1234, 32'h5678, 32'h0, 1, 1'b1, aa);

      // Multiplier-dependent cases (short latency only with early exit)
`ifdef EX_ALU_MUL_EARLY_EXIT_EN
      lat0 = 2;
      lat3 = 3;
`else
      lat0 = 33;
      lat3 = 33;
`endif
      lat8 = 33;
      issue("mul_9x0",   ALU_MUL, 32'd9, 32'd0, 32'd0, lat0, 1'b1, am);
      issue("mul_9x3",   ALU_MUL, 32'd9, 32'd3, 32'd27, lat3, 1'b1, am);
      issue("mul_9xmsb", ALU_MUL, 32'd9, 32'h8000_0000, 32'h8000_0000, lat8, 1'b1, am);

      repeat (45) @(posedge clk);
      #1;
      check("scoreboard.drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule : tb_ex_alu
`default_nettype wire

// File: doc/ex_alu.md
Name: ex_alu

Overview:
- Execute-stage ALU sitting directly downstream of the ALU-control decoder; consumes its 3-bit aluctrl code plus the two operands from the ID/EX register.
- ADD/SUB/AND/OR complete in one cycle.
- MUL runs on an iterative shift-add engine that back-pressures the pipeline through a valid/ready handshake.
- Result and zero flag feed the EX/MEM register.

Parameters:
- WIDTH, 32, operand/result width in bits.
- MUL_BITS, 1, multiplier bits consumed per iteration; must divide WIDTH; N = WIDTH/MUL_BITS.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  operands/aluctrl valid.
- ready_o  out  1  block can accept an operation this cycle.
- aluctrl_i  in  3  op code: AND=000, OR=001, ADD=010, SUB=110, MUL=100.
- data1_i  in  WIDTH  operand A.
- data2_i  in  WIDTH  operand B (multiplier for MUL).
- flush_i  in  1  abort current/incoming op (branch/hazard flush).
- valid_o  out  1  one-cycle pulse, result valid.
- result_o  out  WIDTH  result; held until next valid_o.
- zero_o  out  1  result_o == 0; held with result_o.

Behaviour:
- Reset (rst_i high at a clock edge, also mid-multiply): state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=1, iteration counter=0.
- Accept: an op is accepted at edge T when valid_i && ready_o && !flush_i.
- States:
  - IDLE: ready_o=1.
  - MUL_BUSY: ready_o=0.
- Non-MUL op accepted at T: result registered at T; valid_o high in the cycle after T (latency 1); stays IDLE.
  - ADD/SUB wrap modulo 2^WIDTH, no overflow flag.
  - AND/OR bitwise.
- Undefined aluctrl code: result_o=0, zero_o=1, valid_o still pulses (latency 1).
- MUL accepted at T:
  - Load multiplicand=data1_i, multiplier=data2_i, acc=0; go MUL_BUSY.
  - Edges T+1..T+N each add multiplicand*(low MUL_BITS of multiplier) to acc; multiplicand shifts left MUL_BITS, multiplier shifts right MUL_BITS; counter increments.
  - At edge T+N: result_o = low WIDTH bits of acc, return to IDLE.
  - valid_o and ready_o both high in the following cycle; latency N+1 (33 at defaults).
  - Low-half product only; identical for signed and unsigned.
- Back-to-back: the cycle in which valid_o is high has ready_o=1, so a new op may be accepted on that edge.
- flush_i high at an edge:
  - In MUL_BUSY: abort to IDLE, no valid_o for the aborted op; result_o/zero_o keep their previous values.
  - Coincident with valid_i: the op is not accepted.
  - flush_i has no effect on a valid_o already being driven this cycle.
- valid_i while ready_o=0: ignored; upstream must hold the op (the ID/EX stall is driven from !ready_o).
- No output back-pressure: the consumer always takes valid_o.

Optional Feature:
- Macro: EX_ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL_BUSY also ends at the first iteration edge after which the remaining (shifted) multiplier is zero; result is identical to the full run.
  - Multiplier 0 or 1: latency 2.
  - Multiplier 3 with MUL_BITS=1: latency 3.
- Undefined: fixed latency N+1 regardless of operands.

Decomposition:
- Package alu_pkg: the 3-bit ALUCTRL codes (AND, OR, ADD, SUB, MUL) and the state enum (IDLE, MUL_BUSY). Shared with the ALU-control decoder.
- Sub-module ex_alu_mul_iter: shift-add datapath plus counter with start/abort/done. The top level holds the FSM, the single-cycle ops, and the output registers.

Test Plan:
- ADD 0xFFFFFFFF+1, SUB 5-5, AND 0xF0F0&0xFF00, OR 0x1|0x2, issued back-to-back -> valid_o on each following cycle; results 0 (zero_o=1), 0 (zero_o=1), 0xF000, 0x3; ready_o stays 1.
- MUL 7*6 at default params -> ready_o low for 32 cycles, valid_o 33 cycles after accept, result 42. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- MUL accepted, flush_i pulsed 10 cycles later -> no valid_o, ready_o=1 next cycle, result_o unchanged. ADD 2+3 then accepted -> 5 one cycle later.
- rst_i asserted mid-MUL -> next cycle ready_o=1, valid_o=0, result_o=0, zero_o=1. valid_i with flush_i in the same cycle -> no accept, no valid_o.
- MUL followed by an ADD presented during MUL_BUSY and held -> ADD accepted in the MUL's valid_o cycle; ADD's valid_o one cycle after. aluctrl=111 -> result 0, valid_o pulses.
- With EX_ALU_MUL_EARLY_EXIT_EN: 9*0 -> latency 2, result 0. 9*3 -> latency 3, result 27. 9*0x80000000 -> latency 33, result 0x80000000.
